// File: rtl/vga_frame_capture_if.sv
// ---------------------------------------------------------------------------
// Interfaces for vga_frame_capture.
//
// vga_frame_capture_if : raw VGA signals as seen on the cable.
//     VGA_Clock          pixel clock from the generator (sampled as data)
//     VGA_HS / VGA_VS    horizontal / vertical sync, active low
//     VGA_R/G/B [7:0]    pixel colour
//   master : generator side (drives), slave : capture side (samples)
//
// vga_pixel_if : recovered active-pixel stream.
//     pix_valid          active pixel present this cycle
//     pix_x / pix_y[9:0] pixel coordinates inside the active area
//     pix_rgb [23:0]     {R,G,B}
//     frame_start        pulse with pixel (0,0)
//     frame_done         pulse with the last pixel of the frame
//   master : capture side (drives), slave : consumer side
// ---------------------------------------------------------------------------
interface vga_frame_capture_if;
    logic       VGA_Clock;
    logic       VGA_HS;
    logic       VGA_VS;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    modport master (output VGA_Clock, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B);
    modport slave  (input  VGA_Clock, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B);
endinterface

interface vga_pixel_if;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_rgb;
    logic        frame_start;
    logic        frame_done;

    modport master (output pix_valid, pix_x, pix_y, pix_rgb, frame_start, frame_done);
    modport slave  (input  pix_valid, pix_x, pix_y, pix_rgb, frame_start, frame_done);
endinterface

// File: rtl/vga_frame_capture.sv
// ---------------------------------------------------------------------------
// vga_frame_capture
// Receive side of the VGA timing generator. VGA_Clock, syncs and colour are
// sampled on FPGA_Clock; pixel coordinates are rebuilt from sync edges and
// every active pixel is emitted as a registered stream with frame markers,
// lock status, timing-error pulses and a completed-frame counter.
//
// Ports:
//   FPGA_Clock   system clock, sole clock domain
//   FPGA_Reset   synchronous active-high reset
//   vga          VGA input signals (vga_frame_capture_if.slave)
//   pix          recovered pixel stream (vga_pixel_if.master)
//   locked       vertical sync acquired
//   h_err        one-cycle pulse: line length differs from H_TOTAL
//   v_err        one-cycle pulse: frame length differs from V_TOTAL
//   frame_count  completed frames, wraps
//   frame_sum    (VGA_FRAME_CAPTURE_CHECKSUM_EN only) sum of all pix_rgb
//                values of the last completed frame
//
// Optional feature macro: VGA_FRAME_CAPTURE_CHECKSUM_EN
// ---------------------------------------------------------------------------
module vga_frame_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_TOTAL  = 525
) (
    input  logic                   FPGA_Clock,
    input  logic                   FPGA_Reset,
    vga_frame_capture_if.slave     vga,
    vga_pixel_if.master            pix,
    output logic                   locked,
    output logic                   h_err,
    output logic                   v_err,
`ifdef VGA_FRAME_CAPTURE_CHECKSUM_EN
    output logic [31:0]            frame_sum,
`endif
    output logic [15:0]            frame_count
);

    localparam logic [9:0]  H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  H_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [10:0] H_LEN   = 11'(H_TOTAL);
    localparam logic [10:0] V_LEN   = 11'(V_TOTAL);
    localparam logic [9:0]  POS_MAX = 10'd1023;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        clk_q;
    logic        clk_q_d;
    logic        hs_q;
    logic        vs_q;
    logic [23:0] rgb_q;
    logic        hs_prev;
    logic        vs_prev;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        h_armed;

    logic        tick;
    logic        hs_fall;
    logic        vs_fall;
    logic [9:0]  hpos_nxt;
    logic [9:0]  vpos_nxt;
    logic [9:0]  x_nxt;
    logic [9:0]  y_nxt;
    logic        in_active;
    logic        is_first;
    logic        is_last;
    logic        h_bad;
    logic        v_bad;

    // Input sampling: VGA_Clock is delayed twice for edge detection; the
    // syncs and colour are taken in the same cycle as the first clk stage.
    always_ff @(posedge FPGA_Clock) begin
        if (FPGA_Reset) begin
            clk_q   <= 1'b0;
            clk_q_d <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            rgb_q   <= 24'd0;
        end else begin
            clk_q   <= vga.VGA_Clock;
            clk_q_d <= clk_q;
            hs_q    <= vga.VGA_HS;
            vs_q    <= vga.VGA_VS;
            rgb_q   <= {vga.VGA_R, vga.VGA_G, vga.VGA_B};
        end
    end

    // Tick / sync-edge decode and next raster position. The position that
    // a tick produces is the coordinate of the pixel sampled on that tick.
    always_comb begin
        tick    = clk_q & ~clk_q_d;
        hs_fall = tick & ~hs_q & hs_prev;
        vs_fall = tick & ~vs_q & vs_prev;

        if (hs_fall) begin
            hpos_nxt = 10'd0;
        end else if (tick && (hpos != POS_MAX)) begin
            hpos_nxt = hpos + 10'd1;
        end else begin
            hpos_nxt = hpos;
        end

        // A VS fall normally coincides with an HS fall and must win.
        if (vs_fall) begin
            vpos_nxt = 10'd0;
        end else if (hs_fall && (vpos != POS_MAX)) begin
            vpos_nxt = vpos + 10'd1;
        end else begin
            vpos_nxt = vpos;
        end

        x_nxt     = hpos_nxt - H_START;
        y_nxt     = vpos_nxt - V_START;
        in_active = (state == LOCKED) && tick &&
                    (hpos_nxt >= H_START) && (hpos_nxt <= H_END) &&
                    (vpos_nxt >= V_START) && (vpos_nxt <= V_END);
        is_first  = in_active && (x_nxt == 10'd0)   && (y_nxt == 10'd0);
        is_last   = in_active && (x_nxt == X_LAST)  && (y_nxt == Y_LAST);

        // hpos/vpos hold the index of the last pixel/line, so length = pos+1.
        h_bad = (state == LOCKED) && h_armed && hs_fall &&
                (({1'b0, hpos} + 11'd1) != H_LEN);
        v_bad = (state == LOCKED) && vs_fall &&
                (({1'b0, vpos} + 11'd1) != V_LEN);
    end

    // Sync history and raster counters. h_armed skips the length check of
    // the first HS fall seen at or after lock (no reference fall before it).
    always_ff @(posedge FPGA_Clock) begin
        if (FPGA_Reset) begin
            hs_prev <= 1'b1;
            vs_prev <= 1'b1;
            hpos    <= 10'd0;
            vpos    <= 10'd0;
            h_armed <= 1'b0;
        end else begin
            if (tick) begin
                hs_prev <= hs_q;
                vs_prev <= vs_q;
            end
            hpos <= hpos_nxt;
            vpos <= vpos_nxt;
            if (hs_fall && ((state == LOCKED) || vs_fall)) begin
                h_armed <= 1'b1;
            end
        end
    end

    // Lock FSM state register.
    always_ff @(posedge FPGA_Clock) begin
        if (FPGA_Reset) begin
            state <= UNLOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    // Lock FSM next state: only reset leaves LOCKED.
    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: begin
                if (vs_fall) begin
                    state_nxt = LOCKED;
                end else begin
                    state_nxt = UNLOCKED;
                end
            end
            LOCKED:  state_nxt = LOCKED;
            default: state_nxt = UNLOCKED;
        endcase
    end

    // Registered pixel stream and status; coordinates/colour hold between pixels.
    always_ff @(posedge FPGA_Clock) begin
        if (FPGA_Reset) begin
            pix.pix_valid   <= 1'b0;
            pix.pix_x       <= 10'd0;
            pix.pix_y       <= 10'd0;
            pix.pix_rgb     <= 24'd0;
            pix.frame_start <= 1'b0;
            pix.frame_done  <= 1'b0;
            locked          <= 1'b0;
            h_err           <= 1'b0;
            v_err           <= 1'b0;
            frame_count     <= 16'd0;
        end else begin
            pix.pix_valid   <= in_active;
            pix.frame_start <= is_first;
            pix.frame_done  <= is_last;
            locked          <= (state_nxt == LOCKED);
            h_err           <= h_bad;
            v_err           <= v_bad;
            if (in_active) begin
                pix.pix_x   <= x_nxt;
                pix.pix_y   <= y_nxt;
                pix.pix_rgb <= rgb_q;
            end
            if (is_last) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

`ifdef VGA_FRAME_CAPTURE_CHECKSUM_EN
    logic [31:0] acc;
    logic [31:0] sum_new;

    // Running sum including the current pixel; restarts at the frame origin.
    always_comb begin
        if (is_first) begin
            sum_new = {8'd0, rgb_q};
        end else begin
            sum_new = acc + {8'd0, rgb_q};
        end
    end

    // Accumulator and published per-frame total.
    always_ff @(posedge FPGA_Clock) begin
        if (FPGA_Reset) begin
            acc       <= 32'd0;
            frame_sum <= 32'd0;
        end else begin
            if (in_active) begin
                acc <= sum_new;
            end
            if (is_last) begin
                frame_sum <= sum_new;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_capture
// Directed bench for vga_frame_capture using a reduced raster
// (16x8 active, 26 pixels/line, 15 lines/frame) so whole frames stay short.
// A VGA generator task drives frames; a monitor checks every emitted pixel
// against the expected raster order and colour, and counts pulses.
// ---------------------------------------------------------------------------
module tb_vga_frame_capture;

    localparam int HA = 16;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int HT = 26;
    localparam int VA = 8;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VT = 15;
    localparam int HST = HS + HB;
    localparam int VST = VS + VB;
    localparam int NPIX = HA * VA;

    logic        FPGA_Clock = 1'b0;
    logic        FPGA_Reset = 1'b1;
    logic        locked;
    logic        h_err;
    logic        v_err;
    logic [15:0] frame_count;
`ifdef VGA_FRAME_CAPTURE_CHECKSUM_EN
    logic [31:0] frame_sum;
`endif

    vga_frame_capture_if vif ();
    vga_pixel_if         pif ();

    vga_frame_capture #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT)
    ) dut (
        .FPGA_Clock  (FPGA_Clock),
        .FPGA_Reset  (FPGA_Reset),
        .vga         (vif.slave),
        .pix         (pif.master),
        .locked      (locked),
        .h_err       (h_err),
        .v_err       (v_err),
`ifdef VGA_FRAME_CAPTURE_CHECKSUM_EN
        .frame_sum   (frame_sum),
`endif
        .frame_count (frame_count)
    );

    always #10 FPGA_Clock = ~FPGA_Clock;

    int n_vec  = 0;
    int n_miss = 0;
    int n_valid = 0;
    int n_start = 0;
    int n_done  = 0;
    int n_herr  = 0;
    int n_verr  = 0;
    int idx     = 0;
    int color_mode = 0;
    logic [23:0] const_rgb = 24'd0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Monitor: pixel order/colour and pulse counting, sampled on the falling edge.
    always @(negedge FPGA_Clock) begin
        int ex;
        int ey;
        logic [7:0]  xb;
        logic [7:0]  yb;
        logic [23:0] erg;
        if (FPGA_Reset) begin
            idx = 0;
        end else begin
            if (pif.pix_valid) begin
                ex = idx % HA;
                ey = idx / HA;
                xb = 8'(ex);
                yb = 8'(ey);
                erg = (color_mode == 0) ? {xb, yb, 8'h5A} : const_rgb;
                check_val("pix_x", 64'(pif.pix_x), 64'(ex));
                check_val("pix_y", 64'(pif.pix_y), 64'(ey));
                check_val("pix_rgb", 64'(pif.pix_rgb), 64'(erg));
                n_valid++;
                idx = (idx + 1) % NPIX;
            end
            if (pif.frame_start) begin
                check_val("start_at_origin", {43'd0, pif.pix_valid, pif.pix_x, pif.pix_y},
                          {43'd0, 1'b1, 10'd0, 10'd0});
                n_start++;
            end
            if (pif.frame_done) begin
                check_val("done_at_last", {43'd0, pif.pix_valid, pif.pix_x, pif.pix_y},
                          {43'd0, 1'b1, 10'(HA - 1), 10'(VA - 1)});
                n_done++;
            end
            if (h_err) n_herr++;
            if (v_err) n_verr++;
        end
    end

    // One pixel: clock low with new data, then clock high.
    task automatic drive_pixel(input logic hs, input logic vs, input logic [23:0] rgb);
        @(negedge FPGA_Clock);
        vif.VGA_Clock = 1'b0;
        vif.VGA_HS    = hs;
        vif.VGA_VS    = vs;
        {vif.VGA_R, vif.VGA_G, vif.VGA_B} = rgb;
        @(negedge FPGA_Clock);
        vif.VGA_Clock = 1'b1;
    endtask

    // Pixels p_from..p_to-1 of line l.
    task automatic drive_line(input int l, input int p_from, input int p_to);
        logic [23:0] rgb;
        logic [7:0]  xb;
        logic [7:0]  yb;
        for (int p = p_from; p < p_to; p++) begin
            rgb = 24'd0;
            if (p >= HST && p < HST + HA && l >= VST && l < VST + VA) begin
                xb  = 8'(p - HST);
                yb  = 8'(l - VST);
                rgb = (color_mode == 0) ? {xb, yb, 8'h5A} : const_rgb;
            end
            drive_pixel((p < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1, rgb);
        end
    endtask

    // Lines l_from..l_to-1; the line numbered short_line is one pixel short.
    task automatic drive_frame(input int l_from, input int l_to, input int short_line);
        for (int l = l_from; l < l_to; l++) begin
            drive_line(l, 0, (l == short_line) ? HT - 1 : HT);
        end
    endtask

    task automatic settle();
        repeat (6) @(negedge FPGA_Clock);
    endtask

    int snap_valid;
    int snap_done;

    initial begin
        vif.VGA_Clock = 1'b0;
        vif.VGA_HS = 1'b1;
        vif.VGA_VS = 1'b1;
        vif.VGA_R = 8'd0;
        vif.VGA_G = 8'd0;
        vif.VGA_B = 8'd0;
        repeat (3) @(negedge FPGA_Clock);
        FPGA_Reset = 1'b0;
        @(negedge FPGA_Clock);

        // Reset state
        check_val("rst_valid", 64'(pif.pix_valid), 64'd0);
        check_val("rst_xy_rgb", {20'd0, pif.pix_x, pif.pix_y, pif.pix_rgb}, 64'd0);
        check_val("rst_pulses", {60'd0, pif.frame_start, pif.frame_done, h_err, v_err}, 64'd0);
        check_val("rst_locked", 64'(locked), 64'd0);
        check_val("rst_count", 64'(frame_count), 64'd0);

        // Frame 1: lock on the first VS fall and capture the whole frame
        drive_frame(0, VT, -1);
        settle();
        check_val("f1_valid", 64'(n_valid), 64'(NPIX));
        check_val("f1_start", 64'(n_start), 64'd1);
        check_val("f1_done", 64'(n_done), 64'd1);
        check_val("f1_count", 64'(frame_count), 64'd1);
        check_val("f1_locked", 64'(locked), 64'd1);
        check_val("f1_hold_x", 64'(pif.pix_x), 64'(HA - 1));

        // Frame 2: normal frame, its VS fall checks frame 1 length
        drive_frame(0, VT, -1);
        settle();
        check_val("f2_valid", 64'(n_valid), 64'(2 * NPIX));
        check_val("f2_count", 64'(frame_count), 64'd2);
        check_val("f2_herr", 64'(n_herr), 64'd0);
        check_val("f2_verr", 64'(n_verr), 64'd0);

        // Frame 3: active row 1 one pixel short -> one h_err, stream intact
        drive_frame(0, VT, VST + 1);
        settle();
        check_val("f3_herr", 64'(n_herr), 64'd1);
        check_val("f3_count", 64'(frame_count), 64'd3);
        check_val("f3_valid", 64'(n_valid), 64'(3 * NPIX));

        // Frame 4: one line short (all active lines present)
        drive_frame(0, VT - 1, -1);
        settle();
        check_val("f4_done", 64'(n_done), 64'd4);
        check_val("f4_verr_pending", 64'(n_verr), 64'd0);

        // Frame 5: its VS fall flags frame 4
        drive_frame(0, VT, -1);
        settle();
        check_val("f5_verr", 64'(n_verr), 64'd1);
        check_val("f5_herr", 64'(n_herr), 64'd1);
        check_val("f5_count", 64'(frame_count), 64'd5);

        // Frame 6: reset at active pixel (8,4), then resume mid-frame
        snap_done = n_done;
        drive_frame(0, VST + 4, -1);
        drive_line(VST + 4, 0, HST + 9);
        repeat (4) @(negedge FPGA_Clock);
        check_val("pre_rst_x", 64'(pif.pix_x), 64'd8);
        FPGA_Reset = 1'b1;
        @(negedge FPGA_Clock);
        check_val("mid_rst_valid", 64'(pif.pix_valid), 64'd0);
        check_val("mid_rst_xy_rgb", {20'd0, pif.pix_x, pif.pix_y, pif.pix_rgb}, 64'd0);
        check_val("mid_rst_status", {47'd0, locked, frame_count}, 64'd0);
        @(negedge FPGA_Clock);
        FPGA_Reset = 1'b0;
        snap_valid = n_valid;
        drive_line(VST + 4, HST + 9, HT);
        drive_frame(VST + 5, VT, -1);
        settle();
        check_val("resume_locked", 64'(locked), 64'd0);
        check_val("resume_no_pix", 64'(n_valid - snap_valid), 64'd0);
        check_val("resume_no_done", 64'(n_done - snap_done), 64'd0);

        // Frame 7: fresh VS fall, full capture again
        drive_frame(0, VT, -1);
        settle();
        check_val("f7_count", 64'(frame_count), 64'd1);
        check_val("f7_valid", 64'(n_valid - snap_valid), 64'(NPIX));
        check_val("f7_locked", 64'(locked), 64'd1);
        check_val("f7_done", 64'(n_done - snap_done), 64'd1);

`ifdef VGA_FRAME_CAPTURE_CHECKSUM_EN
        color_mode = 1;
        const_rgb  = 24'h000001;
        drive_frame(0, VT, -1);
        settle();
        check_val("sum_const1", 64'(frame_sum), 64'(NPIX));
        const_rgb  = 24'h000002;
        drive_frame(0, VT, -1);
        settle();
        check_val("sum_const2", 64'(frame_sum), 64'(2 * NPIX));
        check_val("sum_count", 64'(frame_count), 64'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
